// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pops len words from a source FIFO into a 2-deep skid.
// Define FIFO_RD_CNT_EN to add the 16-bit delivered-word counter port word_cnt.
module fifo_rd_ctrl #(
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [N-1:0]     fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_data,
  output logic             busy,
`ifdef FIFO_RD_CNT_EN
  output logic             done,
  output logic [15:0]      word_cnt
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] issue_rem;
  logic [LEN_W-1:0] deliver_rem;
  logic [1:0]       skid_cnt;
  logic             inflight;
  logic [N-1:0]     skid0;
  logic [N-1:0]     skid1;
  logic             pop;
  logic [2:0]       occ;

  assign pop     = m_valid && m_ready;
  assign m_valid = skid_cnt != 2'd0;
  assign m_data  = skid0;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign occ     = {1'b0, skid_cnt} + {2'b00, inflight};

  // Occupancy counts the in-flight word so the skid can never overflow.
  always_comb begin
    fifo_ren = 1'b0;
    if (state == RUN && !fifo_empty &&
        issue_rem != '0 && (occ < 3'd2 || pop))
      fifo_ren = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len != '0) ? RUN : DONE;
      end
      RUN: begin
        if (fifo_ren && issue_rem == LEN_W'(1))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && deliver_rem == LEN_W'(1))
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_rem   <= '0;
      deliver_rem <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= fifo_ren;
      if (state == IDLE) begin
        if (start) begin
          issue_rem   <= len;
          deliver_rem <= len;
        end
      end else begin
        if (fifo_ren)
          issue_rem <= issue_rem - LEN_W'(1);
        if (pop && deliver_rem != '0)
          deliver_rem <= deliver_rem - LEN_W'(1);
      end
    end
  end

  // skid0 is always the head; a write lands behind whatever survives a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_cnt <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      unique case ({inflight, pop})
        2'b10: begin
          if (skid_cnt == 2'd0)
            skid0 <= fifo_rdata;
          else
            skid1 <= fifo_rdata;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= fifo_rdata;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      word_cnt <= 16'd0;
    else if (pop)
      word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl: queue-based FIFO model and in-order scoreboard.
// Define FIFO_RD_CNT_EN to also check the word_cnt port.
module tb_fifo_rd_ctrl;
  localparam int N  = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_ren;
  logic [N-1:0]  fifo_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [N-1:0]  m_data;
  logic          busy;
  logic          done;
`ifdef FIFO_RD_CNT_EN
  logic [15:0]   word_cnt;
`endif

  fifo_rd_ctrl #(.N(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .busy(busy),
`ifdef FIFO_RD_CNT_EN
    .done(done), .word_cnt(word_cnt)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [N-1:0] q[$];
  logic [N-1:0] exp_q[$];
  int blen, pops, dlv, stall_pops;
  int done_cyc, first_cyc, last_cyc;
  bit done_seen, armed, prev_stall, ren_pend, gate;
  logic [N-1:0] prev_data, nxt;
  int rdy_pct = 100;
  int gate_pct = 0;
  int s;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ren_pend)
      fifo_rdata <= nxt;
  end

  // Monitor: FIFO pops, scoreboard compare, hold-while-stalled, done.
  always @(negedge clk) begin
    if (rst || !armed) begin
      prev_stall = 1'b0;
      ren_pend = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      ren_pend = fifo_ren;
      if (fifo_ren) begin
        pops++;
        chk("ren_on_empty", fifo_empty, 0);
        nxt = (q.size() != 0) ? q.pop_front() : '0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0)
          chk("extra_word", 1, 0);
        else
          chk("data", m_data, exp_q.pop_front());
        dlv++;
        if (dlv == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc = cyc;
        chk("burst_words", dlv, blen);
        chk("burst_pops", pops, blen);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    m_ready = int'($urandom_range(99)) < rdy_pct;
    gate = int'($urandom_range(99)) < gate_pct;
    fifo_empty = (q.size() == 0) || gate;
  endtask

  task automatic push_val(input logic [N-1:0] w);
    q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = (q.size() == 0) || gate;
  endtask

  task automatic push_words(input int k);
    for (int i = 0; i < k; i++)
      push_val($urandom);
  endtask

  task automatic burst(input int l, input int stall,
                       input int push_at, input int push_n,
                       output int st);
    int n;
    blen = l;
    pops = 0;
    dlv = 0;
    done_seen = 1'b0;
    stall_pops = 0;
    step();
    start = 1'b1;
    len = LW'(l);
    st = cyc;
    if (stall > 0) m_ready = 1'b0;
    n = 0;
    while (!done_seen && n < 5000) begin
      step();
      start = 1'b0;
      if (n < stall) m_ready = 1'b0;
      if (n == stall) stall_pops = pops;
      if (push_n > 0 && n == push_at) push_words(push_n);
      n++;
    end
    if (!done_seen) begin
      chk("burst_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    #1;
    chk("rst_ren", fifo_ren, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_cnt", word_cnt, 0);
`endif
    step();
    step();
    rst = 1'b0;
    armed = 1'b1;
    // Buffered words are lost; the stream resumes at the FIFO head.
    exp_q.delete();
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  initial begin
    #2;
    do_reset();

    burst(0, 0, 0, 0, s);
    chk("len0_pops", pops, 0);
    chk("len0_done_lat", done_cyc - s, 1);

    burst(4, 0, 4, 4, s);
    chk("late_words", dlv, 4);

    push_val(32'hDEADBEEF);
    push_val(32'hCAFEBABE);
    burst(2, 0, 0, 0, s);
    chk("lat_first", first_cyc - s, 3);
    chk("lat_second", last_cyc - s, 4);
    chk("lat_done", done_cyc - s, 5);

    push_words(8);
    burst(8, 10, 0, 0, s);
    chk("stall_pops", stall_pops, 2);

    for (int k = 0; k < 6; k++) begin
      int l;
      l = int'($urandom_range(20, 1));
      push_words(l + int'($urandom_range(3)));
      rdy_pct = int'($urandom_range(100, 30));
      gate_pct = int'($urandom_range(50));
      burst(l, 0, 0, 0, s);
    end

    push_words(255);
    rdy_pct = 70;
    gate_pct = 20;
    burst(255, 0, 0, 0, s);

    rdy_pct = 100;
    gate_pct = 0;
    push_words(12);
    blen = 8;
    pops = 0;
    dlv = 0;
    step();
    start = 1'b1;
    len = LW'(8);
    for (int n = 0; n < 100 && dlv < 3; n++) begin
      step();
      start = 1'b0;
    end
    chk("mid_dlv", dlv, 3);
    do_reset();
    burst(1, 0, 0, 0, s);
    chk("post_rst_words", dlv, 1);

    do_reset();
    push_words(8);
    burst(3, 0, 0, 0, s);
    burst(5, 0, 0, 0, s);
`ifdef FIFO_RD_CNT_EN
    chk("word_cnt", word_cnt, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter N, default 32, data word width.
REQ-002 Parameter LEN_W, default 8, burst length field width.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  burst request pulse, honoured only in IDLE.
REQ-006 len  input  LEN_W  burst word count, sampled with start.
REQ-007 fifo_empty  input  1  source FIFO empty flag.
REQ-008 fifo_ren  output  1  pop strobe to source FIFO.
REQ-009 fifo_rdata  input  N  pop data, valid the cycle after fifo_ren.
REQ-010 m_valid  output  1  output word available.
REQ-011 m_ready  input  1  downstream accepts word.
REQ-012 m_data  output  N  output word.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse at burst completion.
REQ-015 word_cnt  output  16  total delivered words, present only with FIFO_RD_CNT_EN.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start && len!=0 -> RUN, latching len into issue_rem and deliver_rem; start && len==0 -> DONE, no pops; start outside IDLE ignored.
REQ-018 fifo_ren SHALL be 1 only in RUN with fifo_empty==0, issue_rem!=0, and (skid_cnt + inflight < 2 or m_valid&&m_ready this cycle); each pop decrements issue_rem.
REQ-019 inflight SHALL be a 1-bit register set the cycle after fifo_ren; fifo_rdata then SHALL be written into a 2-entry skid buffer at that edge.
REQ-020 RUN -> DRAIN on the edge where issue_rem reaches 0; DRAIN SHALL never assert fifo_ren.
REQ-021 m_valid = skid_cnt!=0; m_data = skid head; m_valid&&m_ready pops head and decrements deliver_rem.
REQ-022 m_valid/m_data SHALL stay stable while m_valid&&!m_ready.
REQ-023 DRAIN -> DONE on the edge where deliver_rem reaches 0; DONE asserts done for one cycle, then -> IDLE.
REQ-024 Latency: start sampled at edge 0 -> fifo_ren in cycle 1 (FIFO non-empty) -> m_valid in cycle 3; steady state 1 word/cycle with m_ready=1 and FIFO non-empty.
REQ-025 Simultaneous skid write and pop SHALL leave skid_cnt unchanged, order preserved.
REQ-026 fifo_empty high SHALL stall pops without any pop on empty; m_ready low SHALL fill skid to 2 then stall pops, no word lost or duplicated.
REQ-027 Exactly len words SHALL be popped and delivered per burst, len max 2^LEN_W-1.

Reset
REQ-028 rst SHALL force IDLE, fifo_ren=0, m_valid=0, m_data=0, busy=0, done=0, skid_cnt=0, inflight=0, issue_rem=0, deliver_rem=0, word_cnt=0.
REQ-029 rst mid-burst SHALL discard in-flight and buffered data; first post-reset start begins a clean burst.

Configuration
REQ-030 Macro FIFO_RD_CNT_EN defined: word_cnt port present, increments on every m_valid&&m_ready, wraps 65535->0, not cleared between bursts.
REQ-031 FIFO_RD_CNT_EN undefined: word_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 FIFO preloaded 0xDEADBEEF,0xCAFEBABE; start len=2, m_ready=1 -> m_data DEADBEEF then CAFEBABE on consecutive cycles, done one cycle later, busy low after.
REQ-033 start len=0 -> no fifo_ren, done pulses one cycle after start, back to IDLE.
REQ-034 len=8, m_ready=0 for 10 cycles then 1 -> exactly 2 pops during stall, all 8 words in order, no pop beyond 8.
REQ-035 len=4, FIFO empty until cycle 5 then 4 words written -> fifo_ren never high while fifo_empty=1, 4 words delivered.
REQ-036 rst asserted mid-burst of len=8 after 3 deliveries -> all outputs reset values next cycle; new start len=1 delivers next FIFO word.
REQ-037 FIFO_RD_CNT_EN defined, two bursts len=3 and len=5 -> word_cnt=8.
